// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding and
// parameter defaults, also imported by the bench.
package seq_pkg;

  localparam int SEQ_ADDR_W_DEFAULT  = 10;
  localparam int SEQ_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_DONE,
    S_DONE,
    S_ERR
  } seq_state_e;

  // Width of a counter that must reach limit-1; never narrower than one bit.
  function automatic int seq_cnt_width(input int limit);
    return (limit < 3) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Bus between the sequencer, its instruction BRAM and the DSP instruction
// controller. The sequencer drives the master side.
interface inst_sequencer_if #(
  parameter int ADDR_W = seq_pkg::SEQ_ADDR_W_DEFAULT
);

  logic [ADDR_W-1:0] ibram_addr;
  logic              ibram_en;
  logic [31:0]       ibram_dout;
  logic              ctrl_start;
  logic [31:0]       ctrl_inst;
  logic              ctrl_valid;

  modport master (
    output ibram_addr,
    output ibram_en,
    input  ibram_dout,
    output ctrl_start,
    output ctrl_inst,
    input  ctrl_valid
  );

  modport slave (
    input  ibram_addr,
    input  ibram_en,
    output ibram_dout,
    input  ctrl_start,
    input  ctrl_inst,
    output ctrl_valid
  );

endinterface

// File: rtl/inst_sequencer.sv
// Fetches inst_count words from instruction BRAM starting at base_addr and
// hands each to the DSP controller. Define SEQ_TIMEOUT_EN for a completion watchdog.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = SEQ_ADDR_W_DEFAULT,
  parameter int TIMEOUT = SEQ_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] inst_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] issued_cnt,
  inst_sequencer_if.master  bus
);

  seq_state_e        state;
  seq_state_e        state_next;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] issued_q;
  logic [ADDR_W-1:0] issued_inc;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       inst_q;
  logic              last_inst;

  assign issued_inc = issued_q + 1'b1;
  assign last_inst  = (issued_inc == count_q);
  // Address arithmetic wraps at 2^ADDR_W by construction.
  assign fetch_addr = base_q + issued_q;

  assign issued_cnt    = issued_q;
  assign bus.ctrl_inst = inst_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int                WAIT_W    = seq_cnt_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign err          = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    busy           = 1'b1;
    done           = 1'b0;
    bus.ibram_en   = 1'b0;
    bus.ibram_addr = '0;
    bus.ctrl_start = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) begin
          state_next = (inst_count != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        bus.ibram_en   = 1'b1;
        bus.ibram_addr = fetch_addr;
        state_next     = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.ctrl_start = 1'b1;
        state_next     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (bus.ctrl_valid) begin
          state_next = last_inst ? S_DONE : S_FETCH;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wait_expired) begin
          state_next = S_ERR;
        end
`endif
      end
      S_DONE, S_ERR: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Program parameters are captured once so mid-program input changes are harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      inst_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            base_q   <= base_addr;
            count_q  <= inst_count;
            issued_q <= '0;
          end
        end
        S_WAIT_RD: begin
          inst_q <= bus.ibram_dout;
        end
        S_WAIT_DONE: begin
          if (bus.ctrl_valid) begin
            issued_q <= issued_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && run) begin
        err_q <= 1'b0;
      end else if (state_next == S_ERR) begin
        err_q <= 1'b1;
      end
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT_DONE && !bus.ctrl_valid) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 10, width of instruction-BRAM address, base_addr, inst_count, issued_cnt.
REQ-002 Parameter: TIMEOUT, default 16, maximum cycles allowed in WAIT_DONE before error (used only with SEQ_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 run  input  1  start a program, sampled in IDLE only.
REQ-006 base_addr  input  ADDR_W  first instruction address, sampled with run.
REQ-007 inst_count  input  ADDR_W  number of instructions to issue, sampled with run.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse, program finished (normally or by error).
REQ-010 err  output  1  sticky timeout flag, cleared by the next accepted run.
REQ-011 issued_cnt  output  ADDR_W  instructions completed in the current/last program.
REQ-012 ibram_addr  output  ADDR_W  instruction-BRAM read address.
REQ-013 ibram_en  output  1  instruction-BRAM read enable.
REQ-014 ibram_dout  input  32  instruction-BRAM read data, valid one cycle after ibram_en.
REQ-015 ctrl_start  output  1  start pulse to the DSP instruction controller.
REQ-016 ctrl_inst  output  32  instruction word to the controller, held stable from ISSUE until next fetch.
REQ-017 ctrl_valid  input  1  controller completion pulse.

Function
REQ-018 States SHALL be IDLE, FETCH, WAIT_RD, ISSUE, WAIT_DONE, DONE, ERR.
REQ-019 IDLE: run=1 with inst_count!=0 -> FETCH, latching base_addr, inst_count, clearing issued_cnt and err; run=1 with inst_count==0 -> DONE; else stay.
REQ-020 FETCH: ibram_en=1, ibram_addr=base+issued_cnt modulo 2^ADDR_W (wrap-around, no error); -> WAIT_RD.
REQ-021 WAIT_RD: ibram_dout registered into ctrl_inst; -> ISSUE.
REQ-022 ISSUE: ctrl_start=1 for exactly one cycle; -> WAIT_DONE.
REQ-023 WAIT_DONE: on ctrl_valid, issued_cnt increments; -> DONE if issued_cnt+1==latched count, else FETCH.
REQ-024 ctrl_valid outside WAIT_DONE SHALL be ignored (no count change, no state change).
REQ-025 DONE: done=1 for one cycle; -> IDLE. ERR: done=1, err=1 for one cycle; -> IDLE with err held.
REQ-026 run while busy SHALL be ignored; latched base/count unaffected by input changes mid-program.
REQ-027 ibram_en and ctrl_start SHALL be 0 in every state other than FETCH and ISSUE respectively; ibram_addr=0 when ibram_en=0.
REQ-028 Per-instruction overhead: 3 cycles (FETCH, WAIT_RD, ISSUE) plus controller latency; first ctrl_start occurs 3 cycles after run is sampled.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, err=0, issued_cnt=0, ctrl_inst=0, ctrl_start=0, ibram_en=0, ibram_addr=0, wait counter=0, including mid-program (in-flight instruction abandoned).

Configuration
REQ-030 With SEQ_TIMEOUT_EN defined: a wait counter clears on entering WAIT_DONE, increments each WAIT_DONE cycle without ctrl_valid; at TIMEOUT cycles -> ERR; ctrl_valid on the same cycle as expiry wins (normal completion).
REQ-031 Without SEQ_TIMEOUT_EN: no wait counter, WAIT_DONE waits indefinitely, err tied to 0, ERR state unreachable.

Structure
REQ-032 State encoding and default TIMEOUT SHALL live in the shared package (seq_pkg) for reuse by the bench.
REQ-033 No sub-module; single module with one state register, one combinational next-state block, registered datapath.

Verification
REQ-034 run, base=5, count=3, controller model valid 5 cycles after start -> fetch addrs 5,6,7, three ctrl_start pulses, issued_cnt=3, done pulse, err=0.
REQ-035 run, count=0 -> done on cycle after run, no ibram_en, no ctrl_start.
REQ-036 base=1022, count=4 -> fetch addrs 1022,1023,0,1.
REQ-037 SEQ_TIMEOUT_EN, TIMEOUT=16, controller never responds -> ERR after 16 WAIT_DONE cycles, done and err=1, err held until next run; ctrl_valid on 16th cycle -> normal completion.
REQ-038 Second run and stray ctrl_valid during program -> ignored, counts unchanged.
REQ-039 rst_n=0 during WAIT_DONE of instruction 2 -> all outputs at reset values next cycle; new run then restarts from base.
